wb_host_master: RTL and testbench

Wishbone classic single-transfer master (initiator) that drives the user-project Wishbone slave port (`wbs_*`) of `ldpcEncDec` from a simple valid/ready command stream. It is the initiator end of the bus that the LDPC encoder/decoder responds on. It is used as an on-chip host, for example behind a pad-side command bridge, or as the bus driver in the block-level bench. Each command produces exactly one bus cycle and exactly one response, including a timeout error if the slave never acknowledges.

---
 rtl/wb_host_pkg.sv | 16 +
 rtl/wb_timeout_ctr.sv | 31 +++
 rtl/wb_host_master.sv | 90 +++++++++
 tb/tb_wb_host_master.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host master.
// Covers the bus widths, the FSM state encoding and the parameter defaults.
package wb_host_pkg;
   localparam int ADR_W = 32;
   localparam int DAT_W = 32;
   localparam int SEL_W = 4;

   localparam int               DEF_TIMEOUT  = 255;
   localparam logic [DAT_W-1:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating wait counter for one bus cycle.
// It is cleared outside BUS, and expired flags the last cycle the master may wait for ack.
module wb_timeout_ctr
   import wb_host_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int         W    = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
   localparam logic [W-1:0] MAX  = W'(TIMEOUT);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && cnt != MAX)
         cnt <= cnt + 1'b1;
   end

   // cnt equals the index of the current BUS cycle, so LAST marks BUS cycle number TIMEOUT.
   assign expired = (cnt >= LAST);
endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer master driven by a valid/ready command stream.
// It produces one response per command and returns a timeout error if the slave never acks.
module wb_host_master
   import wb_host_pkg::*;
#(
   parameter int               TIMEOUT  = DEF_TIMEOUT,
   parameter logic [DAT_W-1:0] ERR_DATA = DEF_ERR_DATA
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_we,
   input  logic [ADR_W-1:0] cmd_adr,
   input  logic [DAT_W-1:0] cmd_dat,
   input  logic [SEL_W-1:0] cmd_sel,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [DAT_W-1:0] rsp_dat,
   output logic             rsp_err,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [SEL_W-1:0] wbm_sel_o,
   output logic [ADR_W-1:0] wbm_adr_o,
   output logic [DAT_W-1:0] wbm_dat_o,
   input  logic             wbm_ack_i,
   input  logic [DAT_W-1:0] wbm_dat_i
);
   state_t state;
   logic   expired;

   wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .clr     (state != BUS),
      .en      ((state == BUS) && !wbm_ack_i),
      .expired (expired)
   );

   assign cmd_ready = (state == IDLE) && !wb_rst_i;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= '0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_dat   <= '0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               state     <= BUS;
               wbm_cyc_o <= 1'b1;
               wbm_stb_o <= 1'b1;
               wbm_we_o  <= cmd_we;
               wbm_sel_o <= cmd_sel;
               wbm_adr_o <= cmd_adr;
               wbm_dat_o <= cmd_dat;
            end
            // ack is checked first so a same-cycle ack beats the timeout
            BUS: if (wbm_ack_i) begin
               state     <= RESP;
               wbm_cyc_o <= 1'b0;
               wbm_stb_o <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
            end else if (expired) begin
               state     <= RESP;
               wbm_cyc_o <= 1'b0;
               wbm_stb_o <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b1;
               rsp_dat   <= wbm_we_o ? '0 : ERR_DATA;
            end
            RESP: if (rsp_ready) begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master with TIMEOUT=4.
// A small slave model acks after a programmable wait, and a queue holds the expected responses.
module tb_wb_host_master;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
   logic [31:0] cmd_adr = '0, cmd_dat = '0;
   logic [3:0]  cmd_sel = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [31:0] rsp_dat;
   logic        cyc, stb, we, ack;
   logic [3:0]  sel;
   logic [31:0] adr, dat, dat_i;

   int          n_chk = 0, n_fail = 0;
   logic [32:0] sb[$];

   int          bus_cnt = 0, slv_wait = 0;
   logic        slv_en = 1'b0, ack_force = 1'b0;
   logic [31:0] slv_dat = '0;

   logic        e_we;
   logic [3:0]  e_sel;
   logic [31:0] e_adr, e_dat;

   wb_host_master #(.TIMEOUT(4)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
      .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_ack_i(ack), .wbm_dat_i(dat_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bus_cnt <= (cyc && stb) ? bus_cnt + 1 : 0;
   assign ack   = ack_force | (slv_en & cyc & stb & (bus_cnt == slv_wait));
   assign dat_i = slv_dat;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic err_exp, input logic [31:0] rdat_exp);
      int g = 0;
      cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
      e_we = w; e_adr = a; e_dat = d; e_sel = s;
      sb.push_back({err_exp, rdat_exp});
      while (!cmd_ready && g < 50) begin
         @(posedge clk); #1; g++;
      end
      chk("accept_ready", 96'(cmd_ready), 96'(1));
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic bus(input int exp_len, input logic late);
      int n = 0;
      while (cyc && n < 100) begin
         chk("bus_hold", 96'({stb, we, sel, adr, dat}), 96'({1'b1, e_we, e_sel, e_adr, e_dat}));
         n++;
         @(posedge clk); #1;
      end
      ack_force = late;
      chk("cyc_cycles", 96'(n), 96'(exp_len));
      chk("rsp_valid_up", 96'(rsp_valid), 96'(1));
      chk("busy_ready", 96'(cmd_ready), 96'(0));
   endtask

   task automatic resp();
      logic [32:0] e;
      chk("sb_size", 96'(sb.size()), 96'(1));
      e = (sb.size() > 0) ? sb.pop_front() : 33'h0;
      chk("rsp_fields", 96'({rsp_err, rsp_dat}), 96'(e));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      ack_force = 1'b0;
      chk("rsp_valid_down", 96'(rsp_valid), 96'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_bus", 96'({cyc, stb, we, sel, adr, dat}), 96'(0));
      chk("rst_rsp", 96'({rsp_valid, rsp_err, rsp_dat}), 96'(0));
      chk("rst_ready", 96'(cmd_ready), 96'(0));
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_rst", 96'(cmd_ready), 96'(1));

      // write, two wait states
      slv_en = 1'b1; slv_wait = 2;
      issue(1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF, 1'b0, 32'h0);
      bus(3, 1'b0); resp();

      // read, zero wait
      slv_wait = 0; slv_dat = 32'hCAFE_F00D;
      issue(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1'b0, 32'hCAFE_F00D);
      bus(1, 1'b0); resp();

      // write timeout returns zero data
      slv_en = 1'b0;
      issue(1'b1, 32'h3000_0010, 32'hA5A5_5A5A, 4'h3, 1'b1, 32'h0);
      bus(4, 1'b0); resp();

      // read timeout, then late acks must be ignored
      issue(1'b0, 32'h3000_000C, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEEF);
      bus(4, 1'b1); resp();
      ack_force = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         chk("late_ack_no_rsp", 96'(rsp_valid), 96'(0));
         chk("late_ack_idle", 96'(cmd_ready), 96'(1));
      end
      ack_force = 1'b0;

      // ack on the expiry cycle wins
      slv_en = 1'b1; slv_wait = 3; slv_dat = 32'h5555_AAAA;
      issue(1'b0, 32'h3000_0014, 32'h0, 4'h1, 1'b0, 32'h5555_AAAA);
      bus(4, 1'b0); resp();

      // backpressure with the next command waiting
      slv_wait = 1; slv_dat = 32'h1111_2222;
      issue(1'b0, 32'h3000_0020, 32'h0, 4'hC, 1'b0, 32'h1111_2222);
      bus(2, 1'b0);
      cmd_we = 1'b1; cmd_adr = 32'h3000_0030; cmd_dat = 32'h9876_5432; cmd_sel = 4'h6;
      cmd_valid = 1'b1;
      repeat (10) begin
         chk("bp_rsp", 96'({rsp_valid, rsp_err, rsp_dat}), 96'({1'b1, 1'b0, 32'h1111_2222}));
         chk("bp_ready", 96'(cmd_ready), 96'(0));
         chk("bp_cyc", 96'(cyc), 96'(0));
         @(posedge clk); #1;
      end
      resp();
      chk("bp_next_ready", 96'(cmd_ready), 96'(1));
      slv_wait = 0;
      issue(1'b1, 32'h3000_0030, 32'h9876_5432, 4'h6, 1'b0, 32'h0);
      chk("bp_next_cyc", 96'(cyc), 96'(1));
      bus(1, 1'b0); resp();

      // asynchronous reset in the middle of a bus cycle
      slv_en = 1'b0;
      issue(1'b0, 32'h3000_0024, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEEF);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("rst_mid_cyc", 96'({cyc, stb}), 96'(0));
      chk("rst_mid_rsp", 96'(rsp_valid), 96'(0));
      chk("rst_mid_ready", 96'(cmd_ready), 96'(0));
      sb.delete();
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_rst2", 96'(cmd_ready), 96'(1));
      slv_en = 1'b1; slv_wait = 0; slv_dat = 32'h0000_0077;
      issue(1'b0, 32'h3000_0028, 32'h0, 4'hF, 1'b0, 32'h0000_0077);
      bus(1, 1'b0); resp();

      chk("sb_drained", 96'(sb.size()), 96'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
